fc_ram_ctrl: RTL
================

FC_RAM_CTRL -- requirements
Module: fc_ram_ctrl

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 16: data word width, matching the window RAM.
REQ-002 The block SHALL have parameter AWIDTH, default 8: RAM address width; RAM depth is 2**AWIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: starts one load-then-read job; sampled only in IDLE.
REQ-006 The block SHALL have port load_len, input, AWIDTH bits: number of words to load; latched on accepted start.
REQ-007 The block SHALL have port win_cnt, input, AWIDTH bits: number of read windows to issue; latched on accepted start.
REQ-008 The block SHALL have port rd_stride, input, AWIDTH bits: base-address step between windows; latched on accepted start.
REQ-009 The block SHALL have ports s_valid (input, 1), s_data (input, DWIDTH) and s_ready (output, 1): the load stream.
REQ-010 The block SHALL have port rd_en, input, 1 bit: downstream permission to issue the next window.
REQ-011 The block SHALL have ports ram_wren (output, 1), ram_waddr (output, AWIDTH), ram_din (output, DWIDTH) and ram_raddr (output, AWIDTH): they drive the 16-tap window RAM.
REQ-012 The block SHALL have ports win_valid (output, 1) and win_base (output, AWIDTH): RAM taps dout1..dout16 hold words win_base..win_base+15 this cycle.
REQ-013 The block SHALL have ports busy (output, 1) and done (output, 1): job in progress; one-cycle end-of-job pulse.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, READ, DRAIN and FIN.
REQ-015 IDLE: start=1 SHALL latch load_len, win_cnt and rd_stride, clear wr_ptr and rd_base to 0, and go to LOAD; if load_len=0 it SHALL go to READ instead.
REQ-016 LOAD: s_ready SHALL be 1, and ram_wren SHALL equal s_valid combinationally, with ram_waddr=wr_ptr and ram_din=s_data.
REQ-017 LOAD: each s_valid&s_ready cycle SHALL increment wr_ptr; after the load_len-th accepted word the FSM SHALL go to READ.
REQ-018 Outside LOAD: s_ready and ram_wren SHALL be 0, and s_valid SHALL be ignored.
REQ-019 READ: ram_raddr SHALL equal rd_base. A cycle with rd_en=1 SHALL issue that window; it SHALL then add rd_stride to rd_base modulo 2**AWIDTH and count issued windows.
REQ-020 READ with rd_en=0: rd_base and ram_raddr SHALL hold, so that the RAM's registered read address and its outputs stay stable.
REQ-021 win_valid SHALL be a register set in the cycle after an issue, with win_base equal to that issue's rd_base; latency is one cycle, matching the RAM's registered raddr.
REQ-022 After the win_cnt-th issue the FSM SHALL go to DRAIN; if win_cnt=0 at READ entry, it SHALL go to FIN without issuing.
REQ-023 DRAIN SHALL last one cycle, in which the last win_valid is asserted; the FSM SHALL then go to FIN.
REQ-024 FIN: done SHALL be 1 for exactly one cycle, and the FSM SHALL then go to IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE. Start SHALL be ignored while busy=1.
REQ-026 Address arithmetic SHALL wrap modulo 2**AWIDTH with no error flag; window taps beyond the top address wrap inside the RAM.
REQ-027 ram_waddr and ram_din SHALL be 0 outside LOAD. ram_raddr SHALL be 0 in IDLE.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE and clear wr_ptr, rd_base, the window counter, the latched configuration, win_valid, win_base and done to 0, in any state.
REQ-029 During and after reset, every output SHALL be 0. RAM contents are not cleared, and a job interrupted by reset SHALL be abandoned with no done pulse.

Verification
REQ-030 Scenario: load_len=4, win_cnt=2, rd_stride=16, data 0xA0..0xA3, rd_en=1 -> four ram_wren pulses at addresses 0..3; issues at raddr 0 then 16; win_valid with win_base 0, then 16; done one cycle after DRAIN.
REQ-031 Scenario: s_valid toggling 1,0,1,0 during LOAD -> ram_wren only on valid cycles; wr_ptr advances only on them.
REQ-032 Scenario: rd_en=0 for 3 cycles in READ -> ram_raddr held; win_valid=0 in the cycles after the stall; no window skipped or duplicated.
REQ-033 Scenario: rd_stride=0x40, win_cnt=5 with AWIDTH=8 -> win_base sequence 0x00, 0x40, 0x80, 0xC0, 0x00 (wrap).
REQ-034 Scenario: load_len=0, win_cnt=0 -> IDLE to READ to FIN with no writes or issues; done pulses two cycles after start.
REQ-035 Scenario: rst_n=0 mid-READ, then a start pulse while busy -> all outputs 0 next cycle; start while busy ignored; a new job after reset runs from address 0.

Source files
------------

// File: rtl/fc_ram_ctrl_if.sv
// rtl/fc_ram_ctrl_if.sv - job control, load stream, window RAM and status signals of fc_ram_ctrl
interface fc_ram_ctrl_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8
);
  logic              start;
  logic [AWIDTH-1:0] load_len;
  logic [AWIDTH-1:0] win_cnt;
  logic [AWIDTH-1:0] rd_stride;
  logic              s_valid;
  logic [DWIDTH-1:0] s_data;
  logic              s_ready;
  logic              rd_en;
  logic              ram_wren;
  logic [AWIDTH-1:0] ram_waddr;
  logic [DWIDTH-1:0] ram_din;
  logic [AWIDTH-1:0] ram_raddr;
  logic              win_valid;
  logic [AWIDTH-1:0] win_base;
  logic              busy;
  logic              done;

  modport master (
    output start, load_len, win_cnt, rd_stride, s_valid, s_data, rd_en,
    input  s_ready, ram_wren, ram_waddr, ram_din, ram_raddr, win_valid, win_base, busy, done
  );

  modport slave (
    input  start, load_len, win_cnt, rd_stride, s_valid, s_data, rd_en,
    output s_ready, ram_wren, ram_waddr, ram_din, ram_raddr, win_valid, win_base, busy, done
  );
endinterface

// File: rtl/fc_ram_ctrl.sv
// rtl/fc_ram_ctrl.sv - load-then-read job sequencer for the 16-tap window RAM
module fc_ram_ctrl #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  fc_ram_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, READ, DRAIN, FIN} state_t;

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] len_q, wc_q, stride_q;
  logic [AWIDTH-1:0] wr_ptr, rd_base, iss_cnt;
  logic              win_valid_q;
  logic [AWIDTH-1:0] win_base_q;
  logic              accept, issue, start_ok;

  assign start_ok = (state == IDLE) && bus.start;

  // State register; reset abandons any job in flight
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode plus the write-accept and window-issue strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = (bus.load_len == '0) ? READ : LOAD;
      end
      LOAD: begin
        accept = bus.s_valid;
        if (accept && (wr_ptr == len_q - AWIDTH'(1))) state_nxt = READ;
      end
      READ: begin
        if (wc_q == '0) begin
          state_nxt = FIN;
        end else if (bus.rd_en) begin
          issue = 1'b1;
          if (iss_cnt == wc_q - AWIDTH'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN:   state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job configuration, pointers and the one-cycle-delayed window report
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q       <= '0;
      wc_q        <= '0;
      stride_q    <= '0;
      wr_ptr      <= '0;
      rd_base     <= '0;
      iss_cnt     <= '0;
      win_valid_q <= 1'b0;
      win_base_q  <= '0;
    end else begin
      win_valid_q <= issue;
      if (accept) wr_ptr <= wr_ptr + AWIDTH'(1);
      if (issue) begin
        // RAM registers raddr on this edge, so its taps show this base next cycle
        win_base_q <= rd_base;
        rd_base    <= rd_base + stride_q;
        iss_cnt    <= iss_cnt + AWIDTH'(1);
      end
      if (start_ok) begin
        len_q    <= bus.load_len;
        wc_q     <= bus.win_cnt;
        stride_q <= bus.rd_stride;
        wr_ptr   <= '0;
        rd_base  <= '0;
        iss_cnt  <= '0;
      end
    end
  end

  // Output drive; everything is held low while reset is asserted
  always_comb begin
    bus.s_ready   = 1'b0;
    bus.ram_wren  = 1'b0;
    bus.ram_waddr = '0;
    bus.ram_din   = {DWIDTH{1'b0}};
    bus.ram_raddr = '0;
    bus.win_valid = 1'b0;
    bus.win_base  = '0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    if (rst_n) begin
      bus.busy      = (state != IDLE);
      bus.done      = (state == FIN);
      bus.win_valid = win_valid_q;
      bus.win_base  = win_base_q;
      if (state != IDLE) bus.ram_raddr = rd_base;
      if (state == LOAD) begin
        bus.s_ready   = 1'b1;
        bus.ram_wren  = bus.s_valid;
        bus.ram_waddr = wr_ptr;
        bus.ram_din   = bus.s_data;
      end
    end
  end

endmodule
